adder_bist: RTL and testbench
=============================

// Module: adder_bist
// PURPOSE
//  Built-in self-test engine for the CLA/RCA adder pair. Generates operand vectors (two
//  corner vectors, then LFSR pseudo-random) onto the shared adder operand bus, checks both
//  adder results against an internal golden a+b, and counts mismatches per adder. Streams
//  an 8-byte report out through the top-level output mux. Sits upstream of cla/rca
//  (drives a/b, alternative to io_serdes) and downstream of them (consumes cla_z/rca_z).
// PARAMETERS
//  WIDTH        24          operand width; results are WIDTH+1
//  NUM_VECTORS  256         vectors per run, 2..65535; includes the 2 corner vectors
//  SEED_A       24'h5A5A5A  LFSR A seed, non-zero, WIDTH bits
//  SEED_B       24'hC3A51F  LFSR B seed, non-zero, WIDTH bits
//  POLY         24'hE10000  Galois feedback mask, x^24+x^23+x^22+x^17+1
// PORTS
//  clk       in   1        clock
//  rst_n     in   1        synchronous reset, active low
//  start     in   1        level; sampled only in IDLE, starts a run
//  a_o       out  WIDTH    operand A to cla/rca
//  b_o       out  WIDTH    operand B to cla/rca
//  cla_z_i   in   WIDTH+1  CLA sum incl. carry-out
//  rca_z_i   in   WIDTH+1  RCA sum incl. carry-out
//  byte_rd   in   1        pulse; advances report byte pointer while done=1
//  data_o    out  8        current report byte; 0 unless done=1
//  busy      out  1        run in progress
//  done      out  1        report valid
//  pass      out  1        done and both error counters are zero
// BEHAVIOUR
//  Reset: registered on clk while rst_n=0. All outputs 0, FSM IDLE, counters 0, ptr 0.
//  FSM: IDLE -start-> LOAD -> APPLY <-> CHECK -last-> REPORT -start-> LOAD.
//   LOAD: LFSR A<=SEED_A, LFSR B<=SEED_B, idx<=0, cla_err/rca_err<=0, first_fail<=16'hFFFF.
//   APPLY: registers a_o/b_o. idx0: a=all ones, b=1. idx1: a=b=all ones.
//     idx>=2: a=LFSR A, b=LFSR B; both LFSRs step once after use.
//   CHECK: a_o/b_o held. gold={1'b0,a_o}+{1'b0,b_o}, full WIDTH+1 compare.
//     cla_z_i!=gold -> cla_err++; rca_z_i!=gold -> rca_err++. Counters are 16-bit and
//     saturate at 16'hFFFF. First failing idx of either adder -> first_fail, write-once.
//     idx==NUM_VECTORS-1 -> REPORT, else idx++ -> APPLY.
//  Adders are combinational, so one settle cycle (APPLY->CHECK) is enough.
//  Timing: start sampled on edge E; busy=1 from E+1; done=1 from E+2*NUM_VECTORS+2.
//  busy = state in {LOAD,APPLY,CHECK}. a_o/b_o = 0 in IDLE/REPORT.
//  REPORT: data_o = report[ptr]; byte_rd increments ptr, 7 wraps to 0.
//   report: 0:8'hA5  1:cla_err[7:0]  2:cla_err[15:8]  3:rca_err[7:0]  4:rca_err[15:8]
//           5:first_fail[7:0]  6:first_fail[15:8]  7:{pass,cla_err==0,rca_err==0,5'b0}
//  Counters and report persist in REPORT. start in REPORT begins a new run and resets ptr.
//  start during LOAD/APPLY/CHECK is ignored. byte_rd outside REPORT is ignored.
//  start and byte_rd in the same REPORT cycle: start wins.
//  rst_n low mid-run aborts to IDLE and clears everything; no partial report.
// STRUCTURE
//  cejmu_pkg: bist_state_t enum (IDLE, LOAD, APPLY, CHECK, REPORT), BIST_HDR=8'hA5,
//    BIST_RPT_BYTES=8, BIST_CNT_W=16.
//  Sub-module lfsr_gen #(WIDTH, POLY, SEED), instantiated twice. Ports: clk, rst_n,
//    load, step, q. Galois LFSR, load has priority over step.
//  Top: uio_in[1:0] mux selection exposes data_o; BIST drives add_a/add_b when enabled.
// TESTING
//  1 Ideal adders, NUM_VECTORS=16, start pulse -> done at E+34, pass=1;
//    bytes A5 00 00 00 00 FF FF E0.
//  2 rca_z_i bit0 inverted, NUM_VECTORS=16 -> rca_err=16, cla_err=0, first_fail=0,
//    byte7=8'h40, pass=0.
//  3 cla_z_i[24] forced 0 -> idx0 fails (gold 25'h1000000), first_fail=0, cla_err>=2,
//    byte7[6]=0.
//  4 rst_n low for 1 cycle at idx 5 -> next cycle busy=0, a_o=0, data_o=0;
//    new start -> full run with correct report.
//  5 start held high whole run -> exactly one run; restart only after REPORT reached.
//  6 In REPORT, 9 byte_rd pulses -> data_o sequence wraps back to A5 then byte1.
//    start + byte_rd in same cycle -> new run, ptr=0.

Source files
------------

// File: rtl/cejmu_pkg.sv
// Shared types and constants for the adder self-test engine.
// Imported by the BIST top and its LFSR operand generators.
package cejmu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    CHECK,
    REPORT
  } bist_state_t;

  localparam logic [7:0] BIST_HDR       = 8'hA5;
  localparam int         BIST_RPT_BYTES = 8;
  localparam int         BIST_CNT_W     = 16;

endpackage

// File: rtl/adder_bist_lfsr_gen.sv
// Galois LFSR operand generator for the adder BIST.
// Reloads the seed on load; load has priority over step.
module lfsr_gen #(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] POLY  = 24'hE10000,
  parameter logic [WIDTH-1:0] SEED  = 24'h5A5A5A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    unique case (1'b1)
      load: q_d = SEED;
      step: q_d = q_q[0] ? ((q_q >> 1) ^ POLY)
                         : (q_q >> 1);
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/adder_bist.sv
// Self-test engine for the CLA/RCA adder pair: drives operands,
// checks both sums against a golden add, streams an 8-byte report.
module adder_bist
  import cejmu_pkg::*;
#(
  parameter int               WIDTH       = 24,
  parameter int               NUM_VECTORS = 256,
  parameter logic [WIDTH-1:0] SEED_A      = 24'h5A5A5A,
  parameter logic [WIDTH-1:0] SEED_B      = 24'hC3A51F,
  parameter logic [WIDTH-1:0] POLY        = 24'hE10000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH:0] cla_z_i,
  input  logic [WIDTH:0] rca_z_i,
  input  logic           byte_rd,
  output logic [7:0]     data_o,
  output logic           busy,
  output logic           done,
  output logic           pass
);

  localparam int CW = BIST_CNT_W;
  localparam logic [CW-1:0] LAST =
    CW'(NUM_VECTORS - 1);
  localparam logic [CW-1:0] CMAX = '1;

  bist_state_t state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] cla_err_q, cla_err_d;
  logic [CW-1:0] rca_err_q, rca_err_d;
  logic [CW-1:0] ff_q, ff_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic lfsr_load;
  logic lfsr_step;
  logic [WIDTH-1:0] lfsr_a;
  logic [WIDTH-1:0] lfsr_b;
  logic [WIDTH:0]   gold;
  logic cla_bad;
  logic rca_bad;
  logic [7:0] rpt;

  lfsr_gen #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED_A)
  ) u_lfsr_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .q     (lfsr_a)
  );

  lfsr_gen #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED_B)
  ) u_lfsr_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .q     (lfsr_b)
  );

  assign gold    = {1'b0, a_q} + {1'b0, b_q};
  assign cla_bad = (cla_z_i != gold);
  assign rca_bad = (rca_z_i != gold);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cla_err_d = cla_err_q;
    rca_err_d = rca_err_q;
    ff_d      = ff_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        lfsr_load = 1'b1;
        idx_d     = '0;
        cla_err_d = '0;
        rca_err_d = '0;
        ff_d      = '1;
        state_d   = APPLY;
      end
      APPLY: begin
        unique case (1'b1)
          (idx_q == '0): begin
            a_d = '1;
            b_d = WIDTH'(1);
          end
          (idx_q == CW'(1)): begin
            a_d = '1;
            b_d = '1;
          end
          default: begin
            a_d       = lfsr_a;
            b_d       = lfsr_b;
            lfsr_step = 1'b1;
          end
        endcase
        state_d = CHECK;
      end
      CHECK: begin
        if (cla_bad && cla_err_q != CMAX)
          cla_err_d = cla_err_q + 1'b1;
        if (rca_bad && rca_err_q != CMAX)
          rca_err_d = rca_err_q + 1'b1;
        // first_fail is write-once; idx never reaches 16'hFFFF
        if ((cla_bad || rca_bad) && ff_q == CMAX)
          ff_d = idx_q;
        if (idx_q == LAST) begin
          state_d = REPORT;
          ptr_d   = '0;
          a_d     = '0;
          b_d     = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = APPLY;
        end
      end
      REPORT: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else if (byte_rd) begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cla_err_q <= '0;
      rca_err_q <= '0;
      ff_q      <= '0;
      ptr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cla_err_q <= cla_err_d;
      rca_err_q <= rca_err_d;
      ff_q      <= ff_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  assign busy = (state_q == LOAD) ||
                (state_q == APPLY) ||
                (state_q == CHECK);
  assign done = (state_q == REPORT);
  assign pass = done &&
                (cla_err_q == '0) &&
                (rca_err_q == '0);

  always_comb begin
    rpt = 8'h00;
    unique case (ptr_q)
      3'd0: rpt = BIST_HDR;
      3'd1: rpt = cla_err_q[7:0];
      3'd2: rpt = cla_err_q[15:8];
      3'd3: rpt = rca_err_q[7:0];
      3'd4: rpt = rca_err_q[15:8];
      3'd5: rpt = ff_q[7:0];
      3'd6: rpt = ff_q[15:8];
      3'd7: rpt = {pass,
                   cla_err_q == '0,
                   rca_err_q == '0,
                   5'b0};
      default: rpt = 8'h00;
    endcase
  end

  assign data_o = done ? rpt : 8'h00;
  assign a_o    = a_q;
  assign b_o    = b_q;

endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist with a behavioural adder pair
// that can corrupt either sum.
module tb_adder_bist;

  localparam int W = 24;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_o;
  logic [W-1:0] b_o;
  logic [W:0]   cla_z_i;
  logic [W:0]   rca_z_i;
  logic         byte_rd;
  logic [7:0]   data_o;
  logic         busy;
  logic         done;
  logic         pass;

  int   fmode = 0;
  int   n_tot = 0;
  int   n_bad = 0;
  int   cyc;
  logic [7:0] rpt [8];
  logic [W:0] sum;
  logic [15:0] cerr;
  logic        busy_ok;

  always #5 clk = ~clk;

  assign sum     = {1'b0, a_o} + {1'b0, b_o};
  assign cla_z_i = (fmode == 3) ? {1'b0, sum[W-1:0]} : sum;
  assign rca_z_i = (fmode == 2) ? (sum ^ 25'd1) : sum;

  adder_bist #(
    .NUM_VECTORS (N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_o     (a_o),
    .b_o     (b_o),
    .cla_z_i (cla_z_i),
    .rca_z_i (rca_z_i),
    .byte_rd (byte_rd),
    .data_o  (data_o),
    .busy    (busy),
    .done    (done),
    .pass    (pass)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // start a run and wait for done; hold keeps start high
  task automatic run(input bit hold,
                     output int c);
    start = 1'b1;
    c = 0;
    do begin
      tick();
      c++;
      if (!hold) start = 1'b0;
    end while (!done && c < 200);
    chk("run_done", {31'b0, done}, 32'd1);
  endtask

  task automatic read_rpt();
    for (int i = 0; i < 8; i++) begin
      rpt[i] = data_o;
      byte_rd = 1'b1;
      tick();
      byte_rd = 1'b0;
    end
  endtask

  task automatic chk_ideal(input string tag);
    chk({tag, "_b0"}, {24'b0, rpt[0]}, 32'hA5);
    chk({tag, "_b1"}, {24'b0, rpt[1]}, 32'h00);
    chk({tag, "_b2"}, {24'b0, rpt[2]}, 32'h00);
    chk({tag, "_b3"}, {24'b0, rpt[3]}, 32'h00);
    chk({tag, "_b4"}, {24'b0, rpt[4]}, 32'h00);
    chk({tag, "_b5"}, {24'b0, rpt[5]}, 32'hFF);
    chk({tag, "_b6"}, {24'b0, rpt[6]}, 32'hFF);
    chk({tag, "_b7"}, {24'b0, rpt[7]}, 32'hE0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    byte_rd = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_pass", {31'b0, pass}, 0);
    chk("rst_data", {24'b0, data_o}, 0);
    chk("rst_a", {8'b0, a_o}, 0);
    chk("rst_b", {8'b0, b_o}, 0);
    rst_n = 1'b1;
    byte_rd = 1'b1;
    tick();
    byte_rd = 1'b0;
    chk("idle_rd", {24'b0, data_o}, 0);

    // 1: ideal adders
    fmode = 0;
    run(1'b0, cyc);
    chk("t1_lat", cyc, 34);
    chk("t1_pass", {31'b0, pass}, 1);
    chk("t1_busy", {31'b0, busy}, 0);
    chk("t1_a", {8'b0, a_o}, 0);
    read_rpt();
    chk_ideal("t1");

    // 2: rca sum bit0 inverted
    fmode = 2;
    run(1'b0, cyc);
    chk("t2_pass", {31'b0, pass}, 0);
    read_rpt();
    chk("t2_b0", {24'b0, rpt[0]}, 32'hA5);
    chk("t2_cla", {16'b0, rpt[2], rpt[1]}, 0);
    chk("t2_rca", {16'b0, rpt[4], rpt[3]}, 16);
    chk("t2_ff", {16'b0, rpt[6], rpt[5]}, 0);
    chk("t2_b7", {24'b0, rpt[7]}, 32'h40);

    // 3: cla carry-out stuck at 0
    fmode = 3;
    run(1'b0, cyc);
    chk("t3_pass", {31'b0, pass}, 0);
    read_rpt();
    cerr = {rpt[2], rpt[1]};
    chk("t3_cla_ge2", {31'b0, cerr >= 16'd2}, 1);
    chk("t3_rca", {16'b0, rpt[4], rpt[3]}, 0);
    chk("t3_ff", {16'b0, rpt[6], rpt[5]}, 0);
    chk("t3_b7", {24'b0, rpt[7]}, 32'h20);

    // 4: reset pulse mid-run
    fmode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("t4_mid_busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_busy", {31'b0, busy}, 0);
    chk("t4_done", {31'b0, done}, 0);
    chk("t4_a", {8'b0, a_o}, 0);
    chk("t4_data", {24'b0, data_o}, 0);
    tick();
    chk("t4_idle", {31'b0, busy}, 0);
    run(1'b0, cyc);
    chk("t4_lat", cyc, 34);
    read_rpt();
    chk_ideal("t4");

    // 5: start held for the whole run
    busy_ok = 1'b1;
    start = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && cyc < 200);
    chk("t5_lat", cyc, 34);
    chk("t5_busy", {31'b0, busy_ok}, 1);
    tick();
    chk("t5_restart", {31'b0, busy}, 1);
    start = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 200);
    chk("t5_done2", {31'b0, done}, 1);

    // 6: pointer wrap, then start beats byte_rd
    rpt[0] = 8'hA5; rpt[1] = 8'h00;
    rpt[2] = 8'h00; rpt[3] = 8'h00;
    rpt[4] = 8'h00; rpt[5] = 8'hFF;
    rpt[6] = 8'hFF; rpt[7] = 8'hE0;
    chk("t6_p0", {24'b0, data_o}, 32'hA5);
    for (int i = 1; i <= 9; i++) begin
      byte_rd = 1'b1;
      tick();
      byte_rd = 1'b0;
      chk($sformatf("t6_p%0d", i),
          {24'b0, data_o},
          {24'b0, rpt[i % 8]});
    end
    start = 1'b1;
    byte_rd = 1'b1;
    tick();
    start = 1'b0;
    byte_rd = 1'b0;
    chk("t6_busy", {31'b0, busy}, 1);
    cyc = 1;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 200);
    chk("t6_lat", cyc, 34);
    chk("t6_ptr0", {24'b0, data_o}, 32'hA5);

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end

endmodule
